// File: rtl/alu_op_sequencer_if.sv
// Request / ALU / response bundle for alu_op_sequencer.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
// Ports: req_* (request handshake + operands), alu_* (registered operands out, result and flags in),
//        rsp_* (response handshake + captured result/flags), busy, ovf_count.
// slave = the sequencer's view; master = the requester/ALU/consumer environment.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_opcode;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_out;
  logic              alu_negative;
  logic              alu_overflow;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        rsp_flags;

  logic              busy;
  logic [15:0]       ovf_count;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b,
    input  alu_out, alu_negative, alu_overflow, alu_zero,
    input  rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_data, rsp_flags, busy, ovf_count
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b,
    output alu_out, alu_negative, alu_overflow, alu_zero,
    output rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_data, rsp_flags, busy, ovf_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: latch operands, wait LAT settle cycles, capture result/flags.
// Latency: result sampled at edge k+1+LAT after acceptance at edge k; minimum request spacing 3+LAT cycles.
// Backpressure: response held stable until rsp_ready; req_ready only in IDLE, never on a completing edge.
// Ports: clk, rst_n (async active-low), bus (alu_op_sequencer_if.slave: req_*, alu_*, rsp_*, busy, ovf_count).
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int LAT    = 0   // extra ALU settle cycles, 0..15
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_L = 4'(LAT);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [OP_W-1:0]   alu_opcode_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [2:0]        rsp_flags_q;
  logic [15:0]       ovf_q;

  // One-cycle strobes decoded from the current state.
  logic accept;
  logic sample;
  logic done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Returning to IDLE rather than accepting here enforces the 3+LAT spacing.
        if (bus.rsp_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Settle counter: loaded on acceptance, counts down while in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= LAT_L;
    end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Operand registers only change on acceptance so the ALU sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
    end else if (accept) begin
      alu_a_q      <= bus.req_a;
      alu_b_q      <= bus.req_b;
      alu_opcode_q <= bus.req_opcode;
    end
  end

  // Response data/flags persist after the handshake; only the valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 3'b000;
    end else if (sample) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= bus.alu_out;
      rsp_flags_q <= {bus.alu_negative, bus.alu_overflow, bus.alu_zero};
    end else if (done) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Saturating overflow counter, bumped only on sample edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 16'h0000;
    end else if (sample && bus.alu_overflow && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'h0001;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.ovf_count  = ovf_q;

endmodule
